// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and GF(2^8) helpers for the key-schedule slice.
package aes_pkg;

   localparam int unsigned AES_NR = 10;
   localparam int unsigned KEY_W  = 128;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned IDX_W  = 4;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [KEY_W-1:0]  key_t;
   typedef logic [IDX_W-1:0]  idx_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2
   } ks_state_e;

   localparam logic [7:0] RCON_INIT = 8'h01;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ aa;
         aa = xtime(aa);
      end
      return acc;
   endfunction

   // Multiplicative inverse as b^254 (square-and-multiply); maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] e;
      r = 8'h01;
      e = 8'hfe;
      for (int i = 7; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (e[i]) r = gf_mul(r, b);
      end
      return r;
   endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Start/status/read-port bundle between the key-schedule controller and its cipher core.
interface key_schedule_ctrl_if;
   import aes_pkg::*;

   logic start;
   key_t key;
   logic busy;
   logic done;
   logic key_ready;
   idx_t rd_idx;
   key_t rk_out;

   modport master (output start, key, rd_idx, input busy, done, key_ready, rk_out);
   modport slave  (input start, key, rd_idx, output busy, done, key_ready, rk_out);
endinterface

// File: rtl/key_round_step.sv
// One combinational AES-128 key-expansion step: prev round key + rcon -> next round key.
module key_round_step
   import aes_pkg::*;
(
   input  key_t       prev,
   input  logic [7:0] rcon,
   output key_t       next_c
);
   word_t w0, w1, w2, w3;
   word_t rot_c, sub_c, t_c;
   word_t n0, n1, n2, n3;

   assign w0    = prev[127:96];
   assign w1    = prev[95:64];
   assign w2    = prev[63:32];
   assign w3    = prev[31:0];
   assign rot_c = rot_word(w3);

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      sbox u_sbox (
         .endereco (rot_c[8*g +: 8]),
         .dado     (sub_c[8*g +: 8])
      );
   end

   assign t_c    = sub_c ^ {rcon, 24'h000000};
   assign n0     = w0 ^ t_c;
   assign n1     = w1 ^ n0;
   assign n2     = w2 ^ n1;
   assign n3     = w3 ^ n2;
   assign next_c = {n0, n1, n2, n3};
endmodule

// File: rtl/sbox.sv
// AES forward S-box: GF(2^8) inverse followed by the affine transform.
module sbox
   import aes_pkg::*;
(
   input  logic [7:0] endereco,
   output logic [7:0] dado
);
   logic [7:0] inv_c;

   assign inv_c = gf_inv(endereco);
   assign dado  = inv_c ^ {inv_c[6:0], inv_c[7]} ^ {inv_c[5:0], inv_c[7:6]}
                ^ {inv_c[4:0], inv_c[7:5]} ^ {inv_c[3:0], inv_c[7:4]} ^ 8'h63;
endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key schedule: one expansion step per clock into an 11-entry
// round-key store, served through a registered indexed read port.
module key_schedule_ctrl
   import aes_pkg::key_t, aes_pkg::idx_t, aes_pkg::ks_state_e, aes_pkg::IDLE,
          aes_pkg::EXPAND, aes_pkg::READY, aes_pkg::RCON_INIT, aes_pkg::xtime,
          aes_pkg::AES_NR;
#(
   parameter int unsigned NUM_ROUNDS = 10,
   parameter int unsigned KEY_W      = 128
)(
   input  logic                      clk,
   input  logic                      rst_n,
   key_schedule_ctrl_if.slave        bus
);
   if (NUM_ROUNDS != AES_NR || KEY_W != 128) begin : g_bad_cfg
      $error("key_schedule_ctrl supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
   end

   localparam idx_t LAST_IDX = idx_t'(NUM_ROUNDS);

   ks_state_e  state_q, state_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       ready_q, ready_d;
   logic       load_key, step_en;
   idx_t       cnt_q;
   logic [7:0] rcon_q;
   key_t       store_q [NUM_ROUNDS+1];
   key_t       rk_q;
   key_t       prev_c, step_c;

   // State and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      ready_d  = 1'b0;
      load_key = 1'b0;
      step_en  = 1'b0;
      unique case (state_q)
         IDLE, READY: begin
            ready_d = (state_q == READY);
            if (bus.start) begin
               state_d  = EXPAND;
               busy_d   = 1'b1;
               ready_d  = 1'b0;
               load_key = 1'b1;
            end
         end
         EXPAND: begin
            busy_d  = 1'b1;
            step_en = 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = READY;
               busy_d  = 1'b0;
               ready_d = 1'b1;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Guard keeps the previous-key index inside the store outside EXPAND.
   assign prev_c = (cnt_q != '0 && cnt_q <= LAST_IDX) ? store_q[cnt_q - idx_t'(1)] : '0;

   key_round_step u_step (
      .prev   (prev_c),
      .rcon   (rcon_q),
      .next_c (step_c)
   );

   // Counter, rcon, round-key store and read register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         rcon_q <= RCON_INIT;
         rk_q   <= '0;
         for (int unsigned i = 0; i <= NUM_ROUNDS; i++) store_q[i] <= '0;
      end else begin
         rk_q <= (bus.rd_idx <= LAST_IDX) ? store_q[bus.rd_idx] : '0;
         if (load_key) begin
            store_q[0] <= bus.key;
            cnt_q      <= idx_t'(1);
            rcon_q     <= RCON_INIT;
         end else if (step_en) begin
            store_q[cnt_q] <= step_c;
            cnt_q          <= cnt_q + idx_t'(1);
            rcon_q         <= xtime(rcon_q);
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.key_ready = ready_q;
   assign bus.rk_out    = rk_q;
endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Sequential AES-128 key-schedule controller. It replaces the fully unrolled combinational expansion with one round step per clock, using a single shared step datapath (4 S-box lookups). It loads a cipher key on a start handshake and computes the 11 round keys over 10 cycles into an internal round-key store. It then serves round keys to the cipher/decipher core through an indexed, registered read port.

Parameters:
NUM_ROUNDS, 10, number of expansion steps; only 10 (AES-128) is supported. Any other value is a compile-time error.
KEY_W, 128, key/round-key width in bits; fixed at 128.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request expansion of key; sampled only when not busy
key  input  128  cipher key, MSB = byte 0; sampled on the accepted start edge
busy  output  1  high while expansion in progress
done  output  1  one-cycle pulse on the cycle the last round key is written
key_ready  output  1  high while the store holds a complete, valid schedule
rd_idx  input  4  round-key index 0..10 to read
rk_out  output  128  registered round key for rd_idx; 1-cycle latency

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, key_ready=0, rk_out=0; round counter=0; rcon register=8'h01; store contents cleared to 0.
- FSM states: IDLE, EXPAND, READY.
- IDLE/READY, start=1 at edge T:
  - rk[0] <= key.
  - cnt <= 1, rcon <= 8'h01.
  - state <= EXPAND; busy=1, key_ready=0 from T.
- EXPAND, each edge:
  - rk[cnt] <= step(rk[cnt-1], rcon).
  - rcon <= xtime(rcon), i.e. 01,02,04,08,10,20,40,80,1b,36.
  - cnt <= cnt+1.
- EXPAND, edge where cnt==10 (edge T+10):
  - Writes rk[10].
  - state <= READY; busy <= 0; key_ready <= 1; done <= 1 for exactly that cycle.
- Step function (combinational sub-module):
  - w0..w3 = prev words, w0 = prev[127:96].
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}, where RotWord = {w[23:0],w[31:24]}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - Result = {n0,n1,n2,n3}.
- start while busy: ignored; no restart, no error.
- start in READY: key_ready drops at the next edge and a new schedule begins; old keys are overwritten progressively.
- Read port:
  - rk_out <= rk[rd_idx] on every edge, regardless of state.
  - rd_idx > 10 gives rk_out <= 0.
  - Consumers use rk_out only when key_ready=1. During EXPAND, rk_out reflects partially written store contents (defined but not meaningful).
- Mid-operation reset: all state and outputs return to reset values immediately; no done pulse.
- done and key_ready are never asserted while busy=1.

Decomposition:
- Shared package aes_pkg:
  - AES_NR=10 constant.
  - KEY_W constant.
  - Word and key typedefs (32/128-bit).
  - xtime function.
  - rot_word function.
  - Rcon initial value 8'h01.
- One sub-module, key_round_step: combinational single-step expansion containing the 4 sbox instances (existing sbox module, endereco/dado ports).
- key_schedule_ctrl holds the FSM, counter, rcon register, store (11x128 flops) and read register.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse -> busy for 10 cycles; done pulses once at edge T+10; key_ready=1 afterwards; rd_idx=1 -> rk_out=a0fafe1788542cb123a339392a6c7605 one cycle later; rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key -> rk[1]=62636363626363636263636362636363, rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- start held high throughout expansion -> exactly one done pulse; rk[10] correct. Because start is still high when the FSM reaches READY, a second expansion then starts back-to-back.
- Expansion completes, then start with new key 000102030405060708090a0b0c0d0e0f -> key_ready falls at the next edge; after 10 cycles rk[10]=13111d7fe3944a17f307a78b4d2b30c5.
- rst_n asserted at cycle 5 of expansion -> busy, done and key_ready drop asynchronously; rk_out=0; a subsequent start produces a correct schedule.
- rd_idx=11..15 with key_ready=1 -> rk_out=0 one cycle later; rd_idx=0 -> returns the loaded key.
